// File: rtl/ifm_chunk_loader.sv
// IFM chunk loader: fetches one row per ping-pong buffer over a req/gnt/rvalid port and owns ifm_chunk_rdy.
// Optional stall counters are enabled with `define IFM_CHUNK_LOADER_PERF_CNT_EN.
module ifm_chunk_loader #(
    parameter int IFM_ROWS        = 16,
    parameter int WORDS_PER_ROW   = 32,
    parameter int DAT_W           = 64,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             loop_z_idx_start_i,
    input  logic [ADDR_W-1:0]                row_base_addr_i,
    input  logic [ADDR_W-1:0]                row_stride_i,
    output logic                             mem_req_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [DAT_W-1:0]                 mem_rdata_i,
    output logic                             buf_wr_en_o,
    output logic                             buf_wr_sel_o,
    output logic [$clog2(WORDS_PER_ROW)-1:0] buf_wr_addr_o,
    output logic [DAT_W-1:0]                 buf_wr_dat_o,
    input  logic                             inner_loop_finish_i,
    output logic [2:0]                       ifm_chunk_rdy_o,
    output logic                             load_done_o
`ifdef IFM_CHUNK_LOADER_PERF_CNT_EN
    ,
    output logic [31:0]                      stall_buf_cyc_o,
    output logic [31:0]                      stall_mem_cyc_o
`endif
);

    localparam int AW = $clog2(WORDS_PER_ROW);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(IFM_ROWS) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUF, FETCH, COMMIT} state_t;

    state_t            state, state_nxt;
    logic              start_q, start_edge, start_acc;
    logic [ADDR_W-1:0] row_addr, stride_q;
    logic [CW-1:0]     issued, received, outstanding;
    logic [RW-1:0]     row;
    logic              wr_ptr, rel_ptr;
    logic [2:0]        rdy;
    logic              fire, rx, commit, last_row, release_ok;

    assign start_edge = loop_z_idx_start_i & ~start_q;
    assign start_acc  = (state == IDLE) && start_edge;
    assign last_row   = (row == RW'(IFM_ROWS - 1));
    assign fire       = mem_req_o & mem_gnt_i;
    // A release of a buffer that is not full is dropped without moving the pointer.
    assign release_ok = inner_loop_finish_i & rdy[{1'b0, rel_ptr}];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_edge) state_nxt = WAIT_BUF;
            WAIT_BUF: if (!rdy[{1'b0, wr_ptr}]) state_nxt = FETCH;
            FETCH:    if (rx && received == CW'(WORDS_PER_ROW - 1)) state_nxt = COMMIT;
            COMMIT:   state_nxt = last_row ? IDLE : WAIT_BUF;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        rx         = 1'b0;
        commit     = 1'b0;
        case (state)
            FETCH: begin
                mem_req_o  = (issued < CW'(WORDS_PER_ROW)) &&
                             (outstanding < CW'(MAX_OUTSTANDING));
                // Responses only count when something is in flight, so stale rvalids after reset are dropped.
                rx         = mem_rvalid_i && (outstanding != '0);
                if (mem_req_o) mem_addr_o = row_addr + ADDR_W'(issued);
            end
            COMMIT:  commit = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            start_q     <= 1'b0;
            row_addr    <= '0;
            stride_q    <= '0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            row         <= '0;
            wr_ptr      <= 1'b0;
            rel_ptr     <= 1'b0;
            rdy         <= '0;
            load_done_o <= 1'b0;
        end else begin
            start_q     <= loop_z_idx_start_i;
            load_done_o <= 1'b0;
            if (start_acc) begin
                row_addr    <= row_base_addr_i;
                stride_q    <= row_stride_i;
                row         <= '0;
                rdy[2]      <= 1'b0;
                issued      <= '0;
                received    <= '0;
                outstanding <= '0;
            end
            if (fire) issued <= issued + 1'b1;
            if (rx)   received <= received + 1'b1;
            case ({fire, rx})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            if (release_ok) begin
                rdy[{1'b0, rel_ptr}] <= 1'b0;
                rel_ptr              <= ~rel_ptr;
            end
            // Release and commit never hit the same buffer; commit is last so it would win anyway.
            if (commit) begin
                rdy[{1'b0, wr_ptr}] <= 1'b1;
                wr_ptr              <= ~wr_ptr;
                row                 <= row + 1'b1;
                row_addr            <= row_addr + stride_q;
                issued              <= '0;
                received            <= '0;
                if (last_row) begin
                    rdy[2]      <= 1'b1;
                    load_done_o <= 1'b1;
                end
            end
        end
    end

    assign ifm_chunk_rdy_o = rdy;
    assign buf_wr_en_o     = rx;
    assign buf_wr_sel_o    = wr_ptr;
    assign buf_wr_addr_o   = received[AW-1:0];
    assign buf_wr_dat_o    = rx ? mem_rdata_i : '0;

`ifdef IFM_CHUNK_LOADER_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_buf_cyc_o <= '0;
            stall_mem_cyc_o <= '0;
        end else if (start_acc) begin
            stall_buf_cyc_o <= '0;
            stall_mem_cyc_o <= '0;
        end else begin
            if (state == WAIT_BUF && stall_buf_cyc_o != '1)
                stall_buf_cyc_o <= stall_buf_cyc_o + 1'b1;
            if (mem_req_o && !mem_gnt_i && stall_mem_cyc_o != '1)
                stall_mem_cyc_o <= stall_mem_cyc_o + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    release_of_empty_buffer: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        inner_loop_finish_i |-> rdy[{1'b0, rel_ptr}])
        else $error("ifm_chunk_loader: inner_loop_finish on a buffer that is not ready");
`endif

endmodule

// File: tb/tb_ifm_chunk_loader.sv
// Randomized bench for ifm_chunk_loader: memory responder, consumer and a row/word sequence model.
module tb_ifm_chunk_loader;
    localparam int ROWS = 4, W = 4, DW = 64, AWD = 32, MAXO = 2, WA = $clog2(W);

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start_i = 1'b0, gnt = 1'b0, rvalid = 1'b0, finish = 1'b0;
    logic [AWD-1:0] base_i = '0, stride_i = '0;
    logic [DW-1:0]  rdata = '0;
    logic           mem_req, wr_en, wr_sel, load_done;
    logic [AWD-1:0] mem_addr;
    logic [WA-1:0]  wr_addr;
    logic [DW-1:0]  wr_dat;
    logic [2:0]     rdy;
`ifdef IFM_CHUNK_LOADER_PERF_CNT_EN
    logic [31:0]    stall_buf, stall_mem;
`endif

    ifm_chunk_loader #(.IFM_ROWS(ROWS), .WORDS_PER_ROW(W), .DAT_W(DW), .ADDR_W(AWD),
                       .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .loop_z_idx_start_i(start_i),
        .row_base_addr_i(base_i), .row_stride_i(stride_i),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(gnt),
        .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
        .buf_wr_en_o(wr_en), .buf_wr_sel_o(wr_sel), .buf_wr_addr_o(wr_addr),
        .buf_wr_dat_o(wr_dat), .inner_loop_finish_i(finish),
        .ifm_chunk_rdy_o(rdy), .load_done_o(load_done)
`ifdef IFM_CHUNK_LOADER_PERF_CNT_EN
        , .stall_buf_cyc_o(stall_buf), .stall_mem_cyc_o(stall_mem)
`endif
    );

    typedef struct { logic sel; logic [WA-1:0] idx; logic [31:0] addr; logic last_row; } wr_t;
    typedef struct { logic [31:0] addr; int due; } rsp_t;

    logic [31:0] exp_addr[$];
    wr_t         exp_wr[$];
    rsp_t        rsp_q[$];

    int   n_chk = 0, n_fail = 0, cyc = 0, passes = 0;
    logic [2:0] m_rdy = '0;
    logic m_rel = 1'b0, m_wp = 1'b0, m_done = 1'b0, pend_c_sel = 1'b0, pend_c_last = 1'b0;
    int   pend_c = 0, pend_r = 0, tb_outst = 0, last_due = 0, m_stall = 0;
    bit   mem_en = 0, cons_en = 0;
    int   gnt_pct = 100, dly_min = 1, dly_max = 1, gnt_block = 0;

    function automatic logic [63:0] mdata(logic [31:0] a);
        return {a ^ 32'h5A5A_C3C3, a * 32'h9E37_79B1};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // Expected traffic for a whole pass: row r, word w lives at base + r*stride + w.
    task automatic start_pass(logic [31:0] base, logic [31:0] stride);
        logic [31:0] a;
        for (int r = 0; r < ROWS; r++)
            for (int w = 0; w < W; w++) begin
                a = base + stride * 32'(r) + 32'(w);
                exp_addr.push_back(a);
                exp_wr.push_back('{sel: m_wp ^ 1'(r % 2), idx: WA'(w), addr: a, last_row: (r == ROWS - 1)});
            end
        m_wp     = m_wp ^ 1'(ROWS % 2);
        m_rdy[2] = 1'b0;
        m_stall  = 0;
        base_i   = base;
        stride_i = stride;
        start_i  = 1'b1;
    endtask

    task automatic wait_pass(int n);
        for (int i = 0; i < 3000 && passes < n; i++) @(negedge clk);
        #2;
        chk("pass_done", rdy[2], 1);
    endtask

    // Memory responder, consumer and model bookkeeping; acts at each negedge, checks at +1.
    initial begin
        logic g, rv;
        rsp_t r;
        wr_t  w;
        logic [31:0] a;
        int d;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_r > 0) begin
                pend_r--;
                if (pend_r == 0) begin m_rdy[{1'b0, m_rel}] = 1'b0; m_rel = ~m_rel; end
            end
            m_done = 1'b0;
            if (pend_c > 0) begin
                pend_c--;
                if (pend_c == 0) begin
                    m_rdy[{1'b0, pend_c_sel}] = 1'b1;
                    if (pend_c_last) begin m_rdy[2] = 1'b1; m_done = 1'b1; passes++; end
                end
            end
            chk("rdy", rdy, m_rdy);
            chk("done", load_done, m_done);
            if (mem_en) begin
                if (tb_outst >= MAXO) chk("outst_lim", mem_req, 0);
                if (exp_addr.size() == 0) chk("overfetch", mem_req, 0);
                g = 1'b0;
                if (mem_req) begin
                    if (gnt_block > 0) gnt_block--;
                    else g = ($urandom_range(99) < gnt_pct) && (exp_addr.size() > 0);
                    if (!g) m_stall++;
                    if (g) begin
                        a = exp_addr.pop_front();
                        chk("addr", mem_addr, a);
                        d = cyc + $urandom_range(dly_max, dly_min);
                        if (d <= last_due) d = last_due + 1;
                        last_due = d;
                        rsp_q.push_back('{addr: mem_addr, due: d});
                    end
                end
                gnt = g;
                rv = 1'b0;
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    r = rsp_q.pop_front();
                    rv = 1'b1;
                    rdata = mdata(r.addr);
                end else rdata = {$urandom, $urandom};
                rvalid = rv;
                tb_outst += int'(g) - int'(rv);
                #1;
                chk("wr_en", wr_en, rv);
                if (rv && exp_wr.size() == 0) chk("wr_extra", wr_en, 0);
                else if (rv) begin
                    w = exp_wr.pop_front();
                    chk("wr_sel", wr_sel, w.sel);
                    chk("wr_idx", wr_addr, w.idx);
                    chk("wr_dat", wr_dat, mdata(w.addr));
                    chk("wr_free", rdy[{1'b0, w.sel}], 0);
                    if (w.idx == WA'(W - 1)) begin
                        pend_c = 2; pend_c_sel = w.sel; pend_c_last = w.last_row;
                    end
                end
            end else #1;
            if (cons_en && pend_r == 0 && m_rdy[{1'b0, m_rel}] && $urandom_range(3) == 0) begin
                finish = 1'b1; pend_r = 1;
            end else finish = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_wr", wr_en, 0);
        rst_n = 1'b1;

        // Pass A: full grants, 1-cycle responses, first 7 requests stalled, consumer off until both buffers fill.
        mem_en = 1; cons_en = 0; gnt_pct = 100; dly_min = 1; dly_max = 1; gnt_block = 7;
        start_pass(32'h100, 32'h10);
        @(negedge clk); #2;
        chk("lat1_req", mem_req, 0);
        start_i = 1'b0;
        @(negedge clk); #2;
        chk("lat2_req", mem_req, 1);
        chk("lat2_addr", mem_addr, 32'h100);
        for (int i = 0; i < 200 && m_rdy[1:0] != 2'b11; i++) @(negedge clk);
        #2;
        chk("bp_full", rdy, 3'b011);
        repeat (5) @(negedge clk);
        #2;
        chk("bp_req", mem_req, 0);
`ifdef IFM_CHUNK_LOADER_PERF_CNT_EN
        chk("stall_mem7", stall_mem, 32'd7);
`endif
        cons_en = 1;
        wait_pass(1);

        // Pass B: random grants and latency, wrapping addresses, spurious start mid-pass.
        gnt_pct = 60; dly_min = 1; dly_max = 5;
        start_pass($urandom | 32'hFFFF_FF00, $urandom);
        @(negedge clk); #2; start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2; start_i = 1'b1;
        @(negedge clk); #2; start_i = 1'b0;
        wait_pass(2);
`ifdef IFM_CHUNK_LOADER_PERF_CNT_EN
        chk("stall_mem_b", stall_mem, m_stall);
`endif

        // Reset with responses in flight; a late rvalid must not write.
        gnt_pct = 100; dly_min = 8; dly_max = 8;
        start_pass(32'h4000, 32'h40);
        @(negedge clk); #2; start_i = 1'b0;
        for (int i = 0; i < 300 && tb_outst < MAXO; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_en = 0; cons_en = 0; gnt = 1'b0; rvalid = 1'b0; finish = 1'b0;
        exp_addr.delete(); exp_wr.delete(); rsp_q.delete();
        tb_outst = 0; pend_c = 0; pend_r = 0; m_rdy = '0; m_rel = 1'b0; m_wp = 1'b0;
        m_stall = 0; gnt_block = 0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_rdy", rdy, 0);
        chk("arst_wr", wr_en, 0);
        chk("arst_dat", wr_dat, 0);
        repeat (2) @(negedge clk);
        #2; rst_n = 1'b1;
        @(negedge clk); #2;
        rvalid = 1'b1; rdata = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        chk("late_rvalid", wr_en, 0);
        @(negedge clk); #2;
        rvalid = 1'b0;

        // Pass C after reset.
        mem_en = 1; cons_en = 1; gnt_pct = 70; dly_min = 1; dly_max = 4;
        start_pass($urandom, 32'h80);
        @(negedge clk); #2; start_i = 1'b0;
        wait_pass(3);
`ifdef IFM_CHUNK_LOADER_PERF_CNT_EN
        chk("stall_mem_c", stall_mem, m_stall);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
